// File: rtl/controle_forno.sv
// controle_forno: sequencing controller for the microwave oven.
// Accepts a BCD m:ss time setting, a power level, a start strobe, the door
// switch and cancel. Runs the cook cycle (countdown, heater duty cycle,
// turntable, light) and the end-of-cycle buzzer.
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high
//   t        - requested time, BCD [11:8] min, [7:4] tens of s, [3:0] s
//   conf     - start/resume level (rising edge acts)
//   r        - power level, 1..9 direct, 0 or >=10 means full (10)
//   porta    - 1 = door open
//   cancela  - abort, level
//   tempo    - remaining time, BCD m:ss
//   luz, motor, aquec, som - light, turntable, heater, buzzer
//   estado   - 00 OCIOSO, 01 COZINHANDO, 10 PAUSADO, 11 FIM
module controle_forno #(
  parameter int CICLOS_SEG = 1000,
  parameter int BIP_SEG    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] t,
  input  logic        conf,
  input  logic [3:0]  r,
  input  logic        porta,
  input  logic        cancela,
  output logic [11:0] tempo,
  output logic        luz,
  output logic        motor,
  output logic        aquec,
  output logic        som,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    COZINHANDO = 2'b01,
    PAUSADO    = 2'b10,
    FIM        = 2'b11
  } estado_t;

  localparam int PW = (CICLOS_SEG > 1) ? $clog2(CICLOS_SEG) : 1;
  localparam int BW = (BIP_SEG > 1) ? $clog2(BIP_SEG) : 1;

  // A time setting is usable only when it is proper BCD m:ss and non-zero.
  function automatic logic t_valido(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9) && (v != 12'h000);
  endfunction

  // 0 and out-of-range settings mean full power.
  function automatic logic [3:0] pot_limite(input logic [3:0] v);
    if ((v == 4'd0) || (v >= 4'd10)) begin
      return 4'd10;
    end else begin
      return v;
    end
  endfunction

  // One-second BCD decrement: seconds borrow from tens (0 -> 9),
  // tens borrow from minutes (0 -> 5).
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] m, d, s;
    m = v[11:8];
    d = v[7:4];
    s = v[3:0];
    if (s != 4'd0) begin
      s = s - 4'd1;
    end else begin
      s = 4'd9;
      if (d != 4'd0) begin
        d = d - 4'd1;
      end else begin
        d = 4'd5;
        m = m - 4'd1;
      end
    end
    return {m, d, s};
  endfunction

  estado_t       estado_r, estado_prox_s;
  logic [11:0]   tempo_r, tempo_prox_s, tempo_dec_s;
  logic [PW-1:0] pre_r, pre_prox_s;
  logic [3:0]    fase_r, fase_prox_s;
  logic [3:0]    pot_r, pot_prox_s;
  logic [BW-1:0] bip_r, bip_prox_s;
  logic          conf_d_r;
  logic          luz_r, motor_r, aquec_r, som_r;
  logic          luz_prox_s, motor_prox_s, aquec_prox_s, som_prox_s;
  logic          inicio_s, conta_s, seg_s;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    estado_prox_s = estado_r;
    tempo_prox_s  = tempo_r;
    pre_prox_s    = pre_r;
    fase_prox_s   = fase_r;
    pot_prox_s    = pot_r;
    bip_prox_s    = bip_r;
    inicio_s      = conf & ~conf_d_r;
    conta_s       = (estado_r == COZINHANDO) || (estado_r == FIM);
    seg_s         = conta_s && (pre_r == PW'(CICLOS_SEG - 1));
    tempo_dec_s   = bcd_dec(tempo_r);

    // The prescaler keeps running on the cycle the door opens; only the
    // tick's effect on tempo/fase is dropped, so that second is lost.
    if (conta_s) begin
      pre_prox_s = seg_s ? {PW{1'b0}} : pre_r + PW'(1);
    end else begin
      pre_prox_s = pre_r;
    end

    case (estado_r)
      OCIOSO: begin
        if (inicio_s && !porta && t_valido(t)) begin
          estado_prox_s = COZINHANDO;
          tempo_prox_s  = t;
          pre_prox_s    = {PW{1'b0}};
          fase_prox_s   = 4'd0;
          pot_prox_s    = pot_limite(r);
        end else begin
          estado_prox_s = OCIOSO;
        end
      end
      COZINHANDO: begin
        if (cancela) begin
          estado_prox_s = OCIOSO;
          tempo_prox_s  = 12'h000;
        end else if (porta) begin
          estado_prox_s = PAUSADO;
        end else if (seg_s) begin
          tempo_prox_s = tempo_dec_s;
          fase_prox_s  = (fase_r == 4'd9) ? 4'd0 : fase_r + 4'd1;
          if (tempo_dec_s == 12'h000) begin
            estado_prox_s = FIM;
            pre_prox_s    = {PW{1'b0}};
            bip_prox_s    = {BW{1'b0}};
          end else begin
            estado_prox_s = COZINHANDO;
          end
        end else begin
          estado_prox_s = COZINHANDO;
        end
      end
      PAUSADO: begin
        if (cancela) begin
          estado_prox_s = OCIOSO;
          tempo_prox_s  = 12'h000;
        end else if (inicio_s && !porta) begin
          estado_prox_s = COZINHANDO;
        end else begin
          estado_prox_s = PAUSADO;
        end
      end
      FIM: begin
        tempo_prox_s = 12'h000;
        if (inicio_s || porta || cancela) begin
          estado_prox_s = OCIOSO;
        end else if (seg_s) begin
          if (bip_r == BW'(BIP_SEG - 1)) begin
            estado_prox_s = OCIOSO;
          end else begin
            bip_prox_s = bip_r + BW'(1);
          end
        end else begin
          estado_prox_s = FIM;
        end
      end
      default: begin
        estado_prox_s = OCIOSO;
        tempo_prox_s  = 12'h000;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    case (estado_prox_s)
      OCIOSO: begin
        luz_prox_s = porta; motor_prox_s = 1'b0; aquec_prox_s = 1'b0; som_prox_s = 1'b0;
      end
      COZINHANDO: begin
        luz_prox_s = 1'b1; motor_prox_s = 1'b1; som_prox_s = 1'b0;
        aquec_prox_s = (fase_prox_s < pot_prox_s);
      end
      PAUSADO: begin
        luz_prox_s = 1'b1; motor_prox_s = 1'b0; aquec_prox_s = 1'b0; som_prox_s = 1'b0;
      end
      FIM: begin
        luz_prox_s = 1'b0; motor_prox_s = 1'b0; aquec_prox_s = 1'b0; som_prox_s = 1'b1;
      end
      default: begin
        luz_prox_s = 1'b0; motor_prox_s = 1'b0; aquec_prox_s = 1'b0; som_prox_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r <= OCIOSO;
      tempo_r  <= 12'h000;
      pre_r    <= {PW{1'b0}};
      fase_r   <= 4'd0;
      pot_r    <= 4'd0;
      bip_r    <= {BW{1'b0}};
      conf_d_r <= 1'b0;
      luz_r    <= 1'b0;
      motor_r  <= 1'b0;
      aquec_r  <= 1'b0;
      som_r    <= 1'b0;
    end else begin
      estado_r <= estado_prox_s;
      tempo_r  <= tempo_prox_s;
      pre_r    <= pre_prox_s;
      fase_r   <= fase_prox_s;
      pot_r    <= pot_prox_s;
      bip_r    <= bip_prox_s;
      conf_d_r <= conf;
      luz_r    <= luz_prox_s;
      motor_r  <= motor_prox_s;
      aquec_r  <= aquec_prox_s;
      som_r    <= som_prox_s;
    end
  end

  assign tempo  = tempo_r;
  assign estado = estado_r;
  assign luz    = luz_r;
  assign motor  = motor_r;
  assign aquec  = aquec_r;
  assign som    = som_r;

endmodule

// File: tb/tb_controle_forno.sv
// tb_controle_forno: directed test-plan steps followed by randomized inputs,
// every cycle compared against a seconds-based reference model.
module tb_controle_forno;
  localparam int C = 4;
  localparam int B = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] t = 12'h000;
  logic        conf = 1'b0;
  logic [3:0]  r = 4'd0;
  logic        porta = 1'b0;
  logic        cancela = 1'b0;
  logic [11:0] tempo;
  logic        luz, motor, aquec, som;
  logic [1:0]  estado;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: whole seconds remaining, cycle-within-second, phase.
  int   m_state = 0;   // 0 idle, 1 cooking, 2 paused, 3 end
  int   m_rem = 0;
  int   m_cyc = 0;
  int   m_ph = 0;
  int   m_pw = 0;
  int   m_beeps = 0;
  logic m_pconf = 1'b0;
  logic m_luz = 1'b0;

  controle_forno #(.CICLOS_SEG(C), .BIP_SEG(B)) dut (
    .clk(clk), .reset(reset), .t(t), .conf(conf), .r(r), .porta(porta),
    .cancela(cancela), .tempo(tempo), .luz(luz), .motor(motor),
    .aquec(aquec), .som(som), .estado(estado)
  );

  always #5 clk = ~clk;

  function automatic int bcd2s(logic [11:0] v);
    return int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] s2bcd(int s);
    int m, rr;
    m  = s / 60;
    rr = s % 60;
    return {4'(m), 4'(rr / 10), 4'(rr % 10)};
  endfunction

  function automatic bit ok_t(logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9) && (v != 12'h000);
  endfunction

  task automatic model_edge();
    bit st, tk;
    if (reset) begin
      m_state = 0; m_rem = 0; m_cyc = 0; m_ph = 0; m_pw = 0; m_beeps = 0;
      m_pconf = 1'b0; m_luz = 1'b0;
    end else begin
      st = conf && !m_pconf;
      m_pconf = conf;
      tk = (m_state == 1 || m_state == 3) && (m_cyc == C - 1);
      if (m_state == 1 || m_state == 3) m_cyc = (m_cyc + 1) % C;
      case (m_state)
        0: if (st && !porta && ok_t(t)) begin
             m_state = 1; m_rem = bcd2s(t); m_cyc = 0; m_ph = 0;
             m_pw = (r == 4'd0 || r > 4'd9) ? 10 : int'(r);
           end
        1: if (cancela) begin
             m_state = 0; m_rem = 0;
           end else if (porta) begin
             m_state = 2;
           end else if (tk) begin
             m_rem = m_rem - 1;
             m_ph = (m_ph + 1) % 10;
             if (m_rem == 0) begin m_state = 3; m_cyc = 0; m_beeps = 0; end
           end
        2: if (cancela) begin
             m_state = 0; m_rem = 0;
           end else if (st && !porta) begin
             m_state = 1;
           end
        3: if (st || porta || cancela) begin
             m_state = 0;
           end else if (tk) begin
             m_beeps = m_beeps + 1;
             if (m_beeps == B) m_state = 0;
           end
        default: m_state = 0;
      endcase
      m_luz = (m_state == 1) || (m_state == 2) || (m_state == 0 && porta);
    end
  endtask

  task automatic cmp(string tag, logic [11:0] obs, logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp("estado", 12'(estado), 12'(m_state));
    cmp("tempo", tempo, s2bcd(m_rem));
    cmp("luz", 12'(luz), 12'(m_luz));
    cmp("motor", 12'(motor), 12'(m_state == 1));
    cmp("aquec", 12'(aquec), 12'(m_state == 1 && m_ph < m_pw));
    cmp("som", 12'(som), 12'(m_state == 3));
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start(logic [11:0] tv, logic [3:0] rv);
    t = tv; r = rv; conf = 1'b1;
    step();
    conf = 1'b0;
  endtask

  initial begin
    logic [11:0] bad [3];
    bad[0] = 12'h075; bad[1] = 12'h000; bad[2] = 12'h00A;

    // 1: reset held two cycles with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t = 12'($urandom); r = 4'($urandom); conf = 1'($urandom);
      porta = 1'($urandom); cancela = 1'($urandom);
      step();
    end
    cmp("rst_out", {8'h00, luz, motor, aquec, som}, 12'h000);
    cmp("rst_estado", 12'(estado), 12'h000);
    cmp("rst_tempo", tempo, 12'h000);
    reset = 1'b0; conf = 1'b0; porta = 1'b0; cancela = 1'b0;
    step();

    // 2: 5 s at full power
    start(12'h005, 4'd0);
    cmp("t2_start", 12'(estado), 12'h001);
    steps(19);
    cmp("t2_aquec", 12'(aquec), 12'h001);
    step();
    cmp("t2_som", 12'(som), 12'h001);
    cmp("t2_tempo", tempo, 12'h000);
    steps(11);
    cmp("t2_som_last", 12'(som), 12'h001);
    step();
    cmp("t2_ocioso", 12'(estado), 12'h000);

    // 3: minute borrow
    start(12'h100, 4'd5);
    steps(4);
    cmp("t3_059", tempo, 12'h059);
    steps(4);
    cmp("t3_058", tempo, 12'h058);
    cancela = 1'b1; step(); cancela = 1'b0;
    cmp("t3_cancel", tempo, 12'h000);

    // 4: duty cycle at power 3
    start(12'h010, 4'd3);
    steps(11);
    cmp("t4_on", 12'(aquec), 12'h001);
    step();
    cmp("t4_off", 12'(aquec), 12'h000);
    steps(27);
    cmp("t4_last", 12'(estado), 12'h001);
    step();
    cmp("t4_fim", 12'(estado), 12'h003);
    steps(12);

    // 5: door pause and resume; power change while paused is ignored
    start(12'h030, 4'd0);
    steps(5);
    porta = 1'b1;
    step();
    cmp("t5_pause", 12'(estado), 12'h002);
    cmp("t5_tempo", tempo, 12'h029);
    steps(5);
    porta = 1'b0;
    step();
    start(12'h030, 4'd2);
    steps(113);
    cmp("t5_run", tempo, 12'h001);
    step();
    cmp("t5_fim", 12'(estado), 12'h003);
    steps(12);

    // 6: rejected starts, then cancel during FIM
    for (int i = 0; i < 3; i++) begin
      start(bad[i], 4'd0);
      cmp("t6_invalid", 12'(estado), 12'h000);
      step();
    end
    porta = 1'b1;
    start(12'h005, 4'd0);
    cmp("t6_door", 12'(estado), 12'h000);
    cmp("t6_luz", 12'(luz), 12'h001);
    porta = 1'b0;
    step();
    start(12'h001, 4'd0);
    steps(4);
    cmp("t6_fim", 12'(estado), 12'h003);
    steps(2);
    cancela = 1'b1; step(); cancela = 1'b0;
    cmp("t6_cancel", 12'(som), 12'h000);

    // held conf must not retrigger
    t = 12'h002; conf = 1'b1;
    steps(24);
    cmp("held_conf", 12'(estado), 12'h000);
    conf = 1'b0;
    step();

    // reset mid-cycle
    start(12'h009, 4'd4);
    steps(6);
    reset = 1'b1; step(); reset = 1'b0;
    cmp("mid_rst", {estado, tempo[9:0]}, 12'h000);
    step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      conf    = ($urandom_range(0, 5) == 0) ? ~conf : conf;
      porta   = ($urandom_range(0, 29) == 0) ? ~porta : porta;
      cancela = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) t = 12'($urandom);
        else t = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
        r = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
